// File: rtl/shift_seq.sv
// Sequential barrel-free shifter: one bit per cycle, SLL/SRL/SRA or pass-through.
// Result register feeds the ALU result mux; done_o pulses when salida_o is final.
module shift_seq #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [1:0]   operacion_i,
  input  logic         start_i,
  output logic [N-1:0] salida_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_res;
  logic [SW-1:0] r_cnt;
  logic [1:0]    r_op;
  logic          r_busy;
  logic          r_done;

  logic [SW-1:0] w_shamt;
  logic          w_go_shift;
  logic          w_unused_b;

  // Single-bit step of the selected shift; reserved op leaves the value alone.
  function automatic logic [N-1:0] shift_one(input logic [N-1:0] v, input logic [1:0] op);
    logic [N-1:0] r;
    case (op)
      2'b00:   r = {v[N-2:0], 1'b0};
      2'b01:   r = {1'b0, v[N-1:1]};
      2'b10:   r = {v[N-1], v[N-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign w_shamt    = b_i[SW-1:0];
  assign w_go_shift = (w_shamt != '0) && (operacion_i != 2'b11);
  assign w_unused_b = ^b_i[N-1:SW];

  // Control FSM, operand/result registers and registered status flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_res   <= '0;
      r_cnt   <= '0;
      r_op    <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_res <= a_i;
            r_cnt <= w_shamt;
            r_op  <= operacion_i;
            if (w_go_shift) begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_res <= shift_one(r_res, r_op);
          // Counter never wraps: a zero count here is treated as the last step.
          if (r_cnt <= SW'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt - SW'(1);
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign salida_o = r_res;
  assign busy_o   = r_busy;
  assign done_o   = r_done;

endmodule
